// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the parametrised register file.
package reg_file_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } rf_state_t;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: zero-register and range masking, write bypass,
// and the output register. Output is forced to zero outside run mode.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] entry,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] sel;

    // wr_en already excludes dropped writes, so bypass never forwards them
    always_comb begin
        sel = entry;
        if (ZERO_REG != 0 && addr == '0) begin
            sel = '0;
        end else if ({1'b0, addr} >= LIMIT) begin
            sel = '0;
        end else if (BYPASS != 0 && wr_en && wr_addr == addr) begin
            sel = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            out_data <= '0;
        end else begin
            out_data <= sel;
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports, one write port,
// optional hardwired r0, write bypass and a post-reset scrub sequencer.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int                DATA_W    = RF_DATA_W,
    parameter int                ADDR_W    = RF_ADDR_W,
    parameter int                NUM_REGS  = RF_NUM_REGS,
    parameter int                ZERO_REG  = 1,
    parameter int                BYPASS    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              we,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic              ready
);

    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    rf_state_t         state, state_next;
    logic [ADDR_W-1:0] clr_idx, clr_next;
    logic              ready_next;
    logic              scrub_we;
    logic              run_mode;
    logic              run_we;
    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_next;
            ready   <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_next   = clr_idx;
        ready_next = ready;
        scrub_we   = 1'b0;
        case (state)
            ST_CLEAR: begin
                scrub_we = 1'b1;
                clr_next = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_next = ST_RUN;
                    ready_next = 1'b1;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    assign run_mode = (state == ST_RUN);
    assign run_we   = run_mode && we && ({1'b0, rd} < LIMIT) &&
                      !(ZERO_REG != 0 && rd == '0);

    // The array has no reset; the reset edge itself leaves contents alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (scrub_we) begin
                mem[clr_idx] <= RESET_VAL;
            end else if (run_we) begin
                mem[rd] <= i_data;
            end
        end
    end

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_port_a (
        .clk     (clk),
        .rst     (rst),
        .en      (run_mode),
        .addr    (rs),
        .entry   (mem[rs]),
        .wr_en   (run_we),
        .wr_addr (rd),
        .wr_data (i_data),
        .out_data(out_data_a)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_port_b (
        .clk     (clk),
        .rst     (rst),
        .en      (run_mode),
        .addr    (rt),
        .entry   (mem[rt]),
        .wr_en   (run_we),
        .wr_addr (rd),
        .wr_data (i_data),
        .out_data(out_data_b)
    );

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three configurations share one stimulus stream and
// are each compared against an array-based model of the register file.
module tb_reg_file_param;

    localparam logic [31:0] RV1 = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs  = '0;
    logic [4:0]  rt  = '0;
    logic [4:0]  rd  = '0;
    logic        we  = 1'b0;
    logic [31:0] din = '0;

    logic [2:0][31:0] oa;
    logic [2:0][31:0] ob;
    logic [2:0]       rdy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // u0: default; u1: no r0, no bypass, nonzero scrub value; u2: 24 entries
    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1),
                     .BYPASS(1), .RESET_VAL(32'h0)) u0 (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .we(we), .i_data(din),
        .out_data_a(oa[0]), .out_data_b(ob[0]), .ready(rdy[0]));

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(0),
                     .BYPASS(0), .RESET_VAL(RV1)) u1 (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .we(we), .i_data(din),
        .out_data_a(oa[1]), .out_data_b(ob[1]), .ready(rdy[1]));

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .ZERO_REG(1),
                     .BYPASS(1), .RESET_VAL(32'h0)) u2 (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .we(we), .i_data(din),
        .out_data_a(oa[2]), .out_data_b(ob[2]), .ready(rdy[2]));

    // ---------------- reference model ----------------
    logic [31:0] m_mem [3][32];
    int          m_cnt [3];
    bit          m_rdy [3];
    logic [31:0] m_a   [3];
    logic [31:0] m_b   [3];

    function automatic int cfg_n(input int i);
        return (i == 2) ? 24 : 32;
    endfunction
    function automatic bit cfg_z(input int i);
        return i != 1;
    endfunction
    function automatic bit cfg_bp(input int i);
        return i != 1;
    endfunction
    function automatic logic [31:0] cfg_rv(input int i);
        return (i == 1) ? RV1 : 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [4:0] addr,
                                           input bit wr);
        if (cfg_z(i) && addr == 5'd0) return 32'h0;
        if (int'(addr) >= cfg_n(i)) return 32'h0;
        if (cfg_bp(i) && wr && rd == addr) return din;
        return m_mem[i][addr];
    endfunction

    task automatic model_step();
        bit wr;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_rdy[i] = 1'b0;
                m_cnt[i] = 0;
                m_a[i]   = '0;
                m_b[i]   = '0;
            end else if (!m_rdy[i]) begin
                m_mem[i][m_cnt[i]] = cfg_rv(i);
                m_cnt[i]++;
                if (m_cnt[i] == cfg_n(i)) m_rdy[i] = 1'b1;
                m_a[i] = '0;
                m_b[i] = '0;
            end else begin
                wr = we && (int'(rd) < cfg_n(i)) && !(cfg_z(i) && rd == 5'd0);
                m_a[i] = m_read(i, rs, wr);
                m_b[i] = m_read(i, rt, wr);
                if (wr) m_mem[i][rd] = din;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.out_a", i), oa[i], m_a[i]);
            chk($sformatf("u%0d.out_b", i), ob[i], m_b[i]);
            chk($sformatf("u%0d.ready", i), {31'b0, rdy[i]}, {31'b0, m_rdy[i]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic rand_inputs(input bit force_we);
        rd  = 5'($urandom_range(0, 31));
        we  = force_we ? 1'b1 : ($urandom_range(0, 3) != 0);
        din = $urandom;
        rs  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
        rt  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
    endtask

    // Runs from just after rst release; records the edge on which each ready rose
    task automatic scrub_count(input bit noisy, input string tag);
        int e0 = 0;
        int e2 = 0;
        for (int n = 1; n <= 100 && !(rdy[0] && rdy[2]); n++) begin
            if (noisy) rand_inputs(1'b1);
            tick();
            if (rdy[0] && e0 == 0) e0 = n;
            if (rdy[2] && e2 == 0) e2 = n;
        end
        we = 1'b0;
        chk({tag, "_len_u0"}, 32'(e0), 32'd32);
        chk({tag, "_len_u2"}, 32'(e2), 32'd24);
    endtask

    task automatic read_all(input string tag);
        we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs = 5'(a);
            rt = 5'(31 - a);
            tick();
            chk({tag, "_u0"}, oa[0], 32'h0);
            chk({tag, "_u1"}, oa[1], RV1);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] a2;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        RV1,          32'hDEADBEEF};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, RV1,          32'h0};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h12345678, 32'h0};
        vt[4]  = '{1'b1, 5'd7,  32'h11,       5'd1,  5'd2,  32'h0,        32'h0,        RV1,          32'h0};
        vt[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11,       32'hA5A5A5A5};
        vt[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vt[7]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0,        RV1,          32'h0};
        vt[8]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
        vt[9]  = '{1'b1, 5'd30, 32'hFF,       5'd30, 5'd23, 32'hFF,       32'h0,        RV1,          32'h0};
        vt[10] = '{1'b1, 5'd23, 32'h77,       5'd0,  5'd0,  32'h0,        32'h0,        32'h12345678, 32'h0};
        vt[11] = '{1'b0, 5'd0,  32'h0,        5'd23, 5'd30, 32'h77,       32'hFF,       32'h77,       32'h77};

        for (int i = 0; i < 3; i++) begin
            m_rdy[i] = 1'b0;
            m_cnt[i] = 0;
            m_a[i]   = '0;
            m_b[i]   = '0;
            for (int k = 0; k < 32; k++) m_mem[i][k] = '0;
        end

        // Power-on reset and first scrub
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        scrub_count(1'b0, "scrub0");

        for (int k = 0; k < 12; k++) begin
            we  = vt[k].we;
            rd  = vt[k].rd;
            din = vt[k].data;
            rs  = vt[k].rs;
            rt  = vt[k].rt;
            tick();
            chk($sformatf("vec%0d_u0_a", k), oa[0], vt[k].a0);
            chk($sformatf("vec%0d_u0_b", k), ob[0], vt[k].b0);
            chk($sformatf("vec%0d_u1_a", k), oa[1], vt[k].a1);
            chk($sformatf("vec%0d_u2_a", k), oa[2], vt[k].a2);
        end

        // Preload a pattern, then a 2-cycle reset and full scrub
        for (int k = 0; k < 40; k++) begin
            rand_inputs(1'b1);
            tick();
        end
        we  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        scrub_count(1'b0, "scrub1");
        read_all("scrub1_zero");

        // Dirty the array, restart scrub at its 10th edge while writes hammer it
        for (int k = 0; k < 40; k++) begin
            rand_inputs(1'b1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            rand_inputs(1'b1);
            tick();
        end
        chk("mid_scrub_not_ready", {31'b0, rdy[0]}, 32'h0);
        rst = 1'b1;
        rand_inputs(1'b1);
        tick();
        rst = 1'b0;
        scrub_count(1'b1, "scrub2");
        read_all("scrub2_zero");

        // Random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            rand_inputs(1'b0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
